hazard_stall_ctrl: RTL and testbench

- Producer-side hazard controller for the 5-stage RISC-V pipeline. Companion to the EX-stage forwarding unit.
- Detects the hazards forwarding cannot cover:
  - load-use dependency (ID source register = EX load destination);
  - branch-taken redirect in ID;
  - multi-cycle data-memory access in MEM.
- Drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and a global pipeline freeze.
- Keeps a memory-wait FSM with timeout, plus saturating stall and flush counters.

---
 rtl/hazard_stall_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
//============================================================================
// Module      : hazard_stall_ctrl
// Description : Producer-side hazard controller for the 5-stage RISC-V
//               pipeline. Detects load-use dependencies, taken-branch
//               redirects in ID and multi-cycle data-memory accesses in MEM,
//               and drives the PC / IF-ID / ID-EX control strobes plus a
//               global pipeline freeze. Tracks memory waits with a timeout
//               and keeps saturating stall and flush counters.
// Revision    : 1.0 - initial release
//============================================================================
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IDRS1addr_i,
    input  logic [4:0]       IDRS2addr_i,
    input  logic             IDuseRS1_i,
    input  logic             IDuseRS2_i,
    input  logic             EXMemRead_i,
    input  logic [4:0]       EXRDaddr_i,
    input  logic             IDBranchTaken_i,
    input  logic             MEMReq_i,
    input  logic             MEMReady_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IDEXBubble_o,
    output logic             IFIDFlush_o,
    output logic             BranchGo_o,
    output logic             PipeFreeze_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // State encoding of the memory-wait controller
    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ERR      = 2'd2;

    // Last wait_cnt value tolerated before declaring a memory timeout
    localparam logic [15:0] c_WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [15:0] c_WAIT_ONE  = 16'd1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [15:0]      r_wait_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0]       w_state_nxt;
    logic [15:0]      w_wait_cnt_nxt;
    logic             w_timeout_nxt;
    logic             w_lu;
    logic             w_mw;
    logic             w_freeze;

    // Hazard terms: load-use dependency and an outstanding slow memory access
    always_comb begin
        w_lu = EXMemRead_i && (EXRDaddr_i != 5'd0) &&
               ((IDuseRS1_i && (EXRDaddr_i == IDRS1addr_i)) ||
                (IDuseRS2_i && (EXRDaddr_i == IDRS2addr_i)));
        w_mw = MEMReq_i && !MEMReady_i;
        // ERR keeps the pipe frozen permanently; MEM_WAIT releases in the
        // same cycle the memory reports ready.
        w_freeze = ((r_state == c_ST_RUN)      && w_mw)        ||
                   ((r_state == c_ST_MEM_WAIT) && !MEMReady_i) ||
                   (r_state == c_ST_ERR);
    end

    // Pipeline control strobes with priority freeze > load-use > branch
    always_comb begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        IFIDFlush_o  = 1'b0;
        BranchGo_o   = 1'b0;
        PipeFreeze_o = 1'b0;
        if (rst_i) begin
            // everything held low while in reset
        end else if (w_freeze) begin
            PipeFreeze_o = 1'b1;
        end else if (w_lu) begin
            // a taken branch in the same cycle is deferred until the load
            // result is available
            IDEXBubble_o = 1'b1;
        end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
            if (IDBranchTaken_i) begin
                BranchGo_o  = 1'b1;
                IFIDFlush_o = 1'b1;
            end
        end
    end

    // Next-state logic of the memory-wait FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        case (r_state)
            c_ST_RUN: begin
                if (w_mw) begin
                    w_state_nxt    = c_ST_MEM_WAIT;
                    w_wait_cnt_nxt = c_WAIT_ONE;
                end
            end
            c_ST_MEM_WAIT: begin
                if (MEMReady_i) begin
                    w_state_nxt    = c_ST_RUN;
                    w_wait_cnt_nxt = 16'd0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
                    // >= keeps MEM_TIMEOUT=1 from running past the limit
                    if (r_wait_cnt >= c_WAIT_LAST) begin
                        w_state_nxt   = c_ST_ERR;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            c_ST_ERR: begin
                // only reset leaves the error state
            end
            default: begin
                w_state_nxt    = c_ST_RUN;
                w_wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Saturating performance counters for stalled cycles and IF/ID flushes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PCWrite_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (IFIDFlush_o && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign timeout_o   = r_timeout;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed, table-driven bench for hazard_stall_ctrl with
//               hand-written sequences for memory wait, timeout and reset.
// Revision    : 1.0 - initial release
//============================================================================
module tb_hazard_stall_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int c_NVEC      = 12;
    localparam int c_CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [4:0]       IDRS1addr_i, IDRS2addr_i, EXRDaddr_i;
    logic             IDuseRS1_i, IDuseRS2_i, EXMemRead_i;
    logic             IDBranchTaken_i, MEMReq_i, MEMReady_i;
    logic             PCWrite_o, IFIDWrite_o, IDEXBubble_o;
    logic             IFIDFlush_o, BranchGo_o, PipeFreeze_o, timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .IDRS1addr_i(IDRS1addr_i), .IDRS2addr_i(IDRS2addr_i),
        .IDuseRS1_i(IDuseRS1_i), .IDuseRS2_i(IDuseRS2_i),
        .EXMemRead_i(EXMemRead_i), .EXRDaddr_i(EXRDaddr_i),
        .IDBranchTaken_i(IDBranchTaken_i), .MEMReq_i(MEMReq_i),
        .MEMReady_i(MEMReady_i), .PCWrite_o(PCWrite_o),
        .IFIDWrite_o(IFIDWrite_o), .IDEXBubble_o(IDEXBubble_o),
        .IFIDFlush_o(IFIDFlush_o), .BranchGo_o(BranchGo_o),
        .PipeFreeze_o(PipeFreeze_o), .timeout_o(timeout_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    // expected outputs packed as {PCWrite, IFIDWrite, Bubble, Flush, BranchGo, Freeze}
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [c_NVEC];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic logic [5:0] outs();
        return {PCWrite_o, IFIDWrite_o, IDEXBubble_o, IFIDFlush_o, BranchGo_o, PipeFreeze_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        IDRS1addr_i = 5'd0; IDRS2addr_i = 5'd0; IDuseRS1_i = 1'b0; IDuseRS2_i = 1'b0;
        EXMemRead_i = 1'b0; EXRDaddr_i = 5'd0; IDBranchTaken_i = 1'b0;
        MEMReq_i = 1'b0; MEMReady_i = 1'b0;
    endtask

    // Called just after a negedge with inputs driven: check the strobes,
    // advance one clock, update the counter model and check the counters.
    task automatic cycle(input string nm, input logic [5:0] exp);
        #2;
        chk({nm, "_outs"}, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
        if (!exp[5]) exp_stall = (exp_stall < c_CNT_MAX) ? exp_stall + 1 : c_CNT_MAX;
        if (exp[2])  exp_flush = (exp_flush < c_CNT_MAX) ? exp_flush + 1 : c_CNT_MAX;
        chk({nm, "_stall"}, 32'(stall_cnt_o), exp_stall);
        chk({nm, "_flush"}, 32'(flush_cnt_o), exp_flush);
        @(negedge clk);
    endtask

    task automatic async_reset(input string nm);
        #2 rst_i = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk({nm, "_outs"},    32'(outs()),      32'd0);
        chk({nm, "_stall"},   32'(stall_cnt_o), 32'd0);
        chk({nm, "_flush"},   32'(flush_cnt_o), 32'd0);
        chk({nm, "_timeout"}, 32'(timeout_o),   32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        idle_inputs();
    endtask

    initial begin
        //                rs1    rs2    u1 u2 mr  rd     br req rdy  exp
        vecs[0]  = '{5'd0, 5'd0, 1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0,1'b0, 6'b110000}; // idle
        vecs[1]  = '{5'd0, 5'd5, 1'b0,1'b1,1'b1, 5'd5, 1'b0,1'b0,1'b0, 6'b001000}; // load-use rs2
        vecs[2]  = '{5'd0, 5'd0, 1'b0,1'b1,1'b1, 5'd0, 1'b0,1'b0,1'b0, 6'b110000}; // rd = x0
        vecs[3]  = '{5'd0, 5'd5, 1'b0,1'b0,1'b1, 5'd5, 1'b0,1'b0,1'b0, 6'b110000}; // rs2 unused
        vecs[4]  = '{5'd7, 5'd0, 1'b1,1'b0,1'b1, 5'd7, 1'b0,1'b0,1'b0, 6'b001000}; // load-use rs1
        vecs[5]  = '{5'd7, 5'd0, 1'b1,1'b0,1'b0, 5'd7, 1'b0,1'b0,1'b0, 6'b110000}; // not a load
        vecs[6]  = '{5'd0, 5'd0, 1'b0,1'b0,1'b0, 5'd0, 1'b1,1'b0,1'b0, 6'b110110}; // branch
        vecs[7]  = '{5'd3, 5'd0, 1'b1,1'b0,1'b1, 5'd3, 1'b1,1'b0,1'b0, 6'b001000}; // branch + lu
        vecs[8]  = '{5'd0, 5'd0, 1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b1,1'b1, 6'b110000}; // 1-cycle mem
        vecs[9]  = '{5'd0, 5'd0, 1'b0,1'b0,1'b0, 5'd0, 1'b1,1'b1,1'b1, 6'b110110}; // 1-cycle + br
        vecs[10] = '{5'd3, 5'd0, 1'b1,1'b0,1'b1, 5'd4, 1'b0,1'b0,1'b0, 6'b110000}; // rd mismatch
        vecs[11] = '{5'd1, 5'd9, 1'b1,1'b1,1'b1, 5'd9, 1'b0,1'b0,1'b0, 6'b001000}; // rs2 of two

        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outs",    32'(outs()),      32'd0);
        chk("rst_stall",   32'(stall_cnt_o), 32'd0);
        chk("rst_flush",   32'(flush_cnt_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o),   32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            IDRS1addr_i = vecs[i].rs1; IDRS2addr_i = vecs[i].rs2;
            IDuseRS1_i = vecs[i].u1;   IDuseRS2_i = vecs[i].u2;
            EXMemRead_i = vecs[i].mr;  EXRDaddr_i = vecs[i].rd;
            IDBranchTaken_i = vecs[i].br;
            MEMReq_i = vecs[i].req;    MEMReady_i = vecs[i].rdy;
            cycle($sformatf("vec%0d", i), vecs[i].exp);
        end
        idle_inputs();

        // Memory access that needs three wait cycles
        MEMReq_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("memwait%0d", i), 6'b000001);
        MEMReady_i = 1'b1;
        cycle("memdone", 6'b110000);
        idle_inputs();
        cycle("after_mem", 6'b110000);

        // Asynchronous reset in the middle of MEM_WAIT
        MEMReq_i = 1'b1;
        cycle("pre_arst0", 6'b000001);
        cycle("pre_arst1", 6'b000001);
        async_reset("arst");
        cycle("post_arst", 6'b110000);

        // Timeout: MEMReady_i never arrives
        MEMReq_i = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            cycle($sformatf("tmo_wait%0d", i), 6'b000001);
            chk($sformatf("tmo_flag%0d", i), 32'(timeout_o), (i == MEM_TIMEOUT - 1) ? 32'd1 : 32'd0);
        end
        MEMReady_i = 1'b1;
        MEMReq_i   = 1'b0;
        IDBranchTaken_i = 1'b1;
        for (int i = 0; i < 14; i++) cycle($sformatf("err_hold%0d", i), 6'b000001);
        chk("err_stall_sat", 32'(stall_cnt_o), 32'(c_CNT_MAX));
        chk("err_timeout",   32'(timeout_o),   32'd1);
        async_reset("err_rst");
        cycle("post_err_rst", 6'b110000);

        // Flush counter saturation
        IDBranchTaken_i = 1'b1;
        for (int i = 0; i < c_CNT_MAX + 2; i++) cycle($sformatf("br%0d", i), 6'b110110);
        chk("flush_sat", 32'(flush_cnt_o), 32'(c_CNT_MAX));
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
